// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave.
// Contents: FSM state encodings (also exported on the debug state port),
// byte/pointer widths, and the wrapping register-pointer increment.
package i2c_pkg;

   localparam int BITS_PER_BYTE = 8;
   localparam int PTR_W         = 4;

   // Index of the last bit in a byte, sized to the bit counter.
   localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_WRITE     = 3'd3;
   localparam logic [2:0] ST_WRITE_ACK = 3'd4;
   localparam logic [2:0] ST_READ      = 3'd5;
   localparam logic [2:0] ST_READ_ACK  = 3'd6;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      ADDR      = ST_ADDR,
      ADDR_ACK  = ST_ADDR_ACK,
      WRITE     = ST_WRITE,
      WRITE_ACK = ST_WRITE_ACK,
      READ      = ST_READ,
      READ_ACK  = ST_READ_ACK
   } state_t;

   // Advance the register pointer, wrapping from num_regs-1 back to 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                 input int num_regs);
      if (p == PTR_W'(num_regs - 1)) return '0;
      else                           return p + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for one I2C pad line.
// Two-flop synchronizer (flops reset to 1 = idle bus), optional 3-sample
// majority filter, and single-cycle rise/fall detection.
// Optional feature macro: I2C_GLITCH_FILTER_EN (adds the majority filter,
// rejects 1-clk spikes, event latency 5 clk instead of 3 clk).
// Ports:
//   clk, rst  : fabric clock, async active-high reset
//   i_line    : raw pad input
//   o_level   : conditioned line level
//   o_rise    : one-cycle pulse on a conditioned rising edge
//   o_fall    : one-cycle pulse on a conditioned falling edge
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic w_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [2:0] r_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_win <= 3'b111;
      else     r_win <= {r_win[1:0], r_sync};
   end

   // Two of the last three samples must agree, so a lone 1-clk sample is lost.
   assign w_level = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) |
                    (r_win[1] & r_win[2]);
`else
   assign w_level = r_sync;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prev <= 1'b1;
      else     r_prev <= w_level;
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave with a byte-wide, host-writable register file.
// Write: address/W, pointer byte, then auto-incrementing data bytes.
// Read:  address/R, bytes auto-increment from the current pointer.
// Repeated START supported. SDA is open-drain via sda_oe.
// Optional feature macro: I2C_GLITCH_FILTER_EN (forwarded to i2c_line_sync).
// Ports:
//   clk, rst : fabric clock, async active-high reset
//   scl      : raw SCL pad input
//   sda_in   : raw SDA pad input
//   sda_oe   : 1 = pull SDA low
//   reg_q    : register file, reg i at [8i+7:8i]
//   wr_stb   : one-cycle pulse when a register is written
//   wr_idx   : index of the written register (valid with wr_stb)
//   state    : current FSM state (debug)
//   busy     : high from a detected START until a detected STOP
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h24,
   parameter int         NUM_REGS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic [NUM_REGS*8-1:0] reg_q,
   output logic                  wr_stb,
   output logic [3:0]            wr_idx,
   output logic [2:0]            state,
   output logic                  busy
);

   logic w_scl_level, w_scl_rise, w_scl_fall;
   logic w_sda_level, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_line_sync u_scl_sync (
      .clk     (clk),
      .rst     (rst),
      .i_line  (scl),
      .o_level (w_scl_level),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk     (clk),
      .rst     (rst),
      .i_line  (sda_in),
      .o_level (w_sda_level),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   // Both lines share the same pipeline depth, so SCL level is coherent with SDA edges.
   assign w_start = w_sda_fall & w_scl_level;
   assign w_stop  = w_sda_rise & w_scl_level;

   state_t                r_state, w_state;
   logic [2:0]            r_bit_cnt, w_bit_cnt;
   logic [7:0]            r_shift, w_shift;
   logic [7:0]            r_tx, w_tx;
   logic [PTR_W-1:0]      r_ptr, w_ptr;
   logic                  r_ptr_loaded, w_ptr_loaded;
   logic                  r_drop, w_drop;
   logic                  r_ack, w_ack;
   logic                  r_ack_on, w_ack_on;   // ACK bit currently being driven
   logic                  r_rw, w_rw;
   logic                  r_sda_oe, w_sda_oe;
   logic                  r_busy, w_busy;
   logic [NUM_REGS*8-1:0] r_regs, w_regs;
   logic                  r_wr_stb, w_wr_stb;
   logic [3:0]            r_wr_idx, w_wr_idx;

   logic [7:0]            w_byte;
   logic [7:0]            w_cur_byte;
   logic [7:0]            w_next_byte;
   logic [PTR_W-1:0]      w_ptr_inc;

   assign w_byte      = {r_shift[6:0], w_sda_level};
   assign w_ptr_inc   = ptr_inc(r_ptr, NUM_REGS);
   assign w_cur_byte  = r_regs[{r_ptr, 3'b000} +: 8];
   assign w_next_byte = r_regs[{w_ptr_inc, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_tx         <= '0;
         r_ptr        <= '0;
         r_ptr_loaded <= 1'b0;
         r_drop       <= 1'b0;
         r_ack        <= 1'b0;
         r_ack_on     <= 1'b0;
         r_rw         <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_busy       <= 1'b0;
         r_regs       <= '0;
         r_wr_stb     <= 1'b0;
         r_wr_idx     <= '0;
      end else begin
         r_state      <= w_state;
         r_bit_cnt    <= w_bit_cnt;
         r_shift      <= w_shift;
         r_tx         <= w_tx;
         r_ptr        <= w_ptr;
         r_ptr_loaded <= w_ptr_loaded;
         r_drop       <= w_drop;
         r_ack        <= w_ack;
         r_ack_on     <= w_ack_on;
         r_rw         <= w_rw;
         r_sda_oe     <= w_sda_oe;
         r_busy       <= w_busy;
         r_regs       <= w_regs;
         r_wr_stb     <= w_wr_stb;
         r_wr_idx     <= w_wr_idx;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_bit_cnt    = r_bit_cnt;
      w_shift      = r_shift;
      w_tx         = r_tx;
      w_ptr        = r_ptr;
      w_ptr_loaded = r_ptr_loaded;
      w_drop       = r_drop;
      w_ack        = r_ack;
      w_ack_on     = r_ack_on;
      w_rw         = r_rw;
      w_sda_oe     = r_sda_oe;
      w_busy       = r_busy;
      w_regs       = r_regs;
      w_wr_stb     = 1'b0;
      w_wr_idx     = r_wr_idx;

      // START/STOP outrank any bit event seen in the same cycle.
      if (w_start) begin
         w_state      = ADDR;
         w_bit_cnt    = '0;
         w_ptr_loaded = 1'b0;
         w_drop       = 1'b0;
         w_ack_on     = 1'b0;
         w_sda_oe     = 1'b0;
         w_busy       = 1'b1;
      end else if (w_stop) begin
         w_state  = IDLE;
         w_drop   = 1'b0;
         w_ack_on = 1'b0;
         w_sda_oe = 1'b0;
         w_busy   = 1'b0;
      end else begin
         case (r_state)
            IDLE: ;
            ADDR: begin
               if (w_scl_rise) begin
                  w_shift = w_byte;
                  if (r_bit_cnt == LAST_BIT) begin
                     w_bit_cnt = '0;
                     w_rw      = w_sda_level;
                     w_ack_on  = 1'b0;
                     w_state   = (w_byte[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
                  end else begin
                     w_bit_cnt = r_bit_cnt + 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               // First fall starts the ACK bit, second fall ends it.
               if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     w_sda_oe = 1'b1;
                     w_ack_on = 1'b1;
                  end else begin
                     w_ack_on  = 1'b0;
                     w_bit_cnt = '0;
                     if (r_rw) begin
                        w_state  = READ;
                        w_tx     = w_cur_byte;
                        w_sda_oe = ~w_cur_byte[7];
                     end else begin
                        w_state  = WRITE;
                        w_sda_oe = 1'b0;
                     end
                  end
               end
            end
            WRITE: begin
               if (w_scl_rise) begin
                  w_shift = w_byte;
                  if (r_bit_cnt == LAST_BIT) begin
                     w_bit_cnt = '0;
                     w_ack_on  = 1'b0;
                     w_state   = WRITE_ACK;
                     if (r_drop) begin
                        w_ack = 1'b0;
                     end else if (!r_ptr_loaded) begin
                        if (w_byte < 8'(NUM_REGS)) begin
                           w_ptr        = w_byte[PTR_W-1:0];
                           w_ptr_loaded = 1'b1;
                           w_ack        = 1'b1;
                        end else begin
                           w_drop = 1'b1;
                           w_ack  = 1'b0;
                        end
                     end else begin
                        w_regs[{r_ptr, 3'b000} +: 8] = w_byte;
                        w_wr_stb = 1'b1;
                        w_wr_idx = r_ptr;
                        w_ack    = 1'b1;
                        w_ptr    = w_ptr_inc;
                     end
                  end else begin
                     w_bit_cnt = r_bit_cnt + 1'b1;
                  end
               end
            end
            WRITE_ACK: begin
               if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     w_sda_oe = r_ack;
                     w_ack_on = 1'b1;
                  end else begin
                     w_sda_oe = 1'b0;
                     w_ack_on = 1'b0;
                     w_state  = WRITE;
                  end
               end
            end
            READ: begin
               // Bit 7 was presented on entry; each fall moves to the next bit.
               if (w_scl_fall) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     w_sda_oe = 1'b0;
                     w_state  = READ_ACK;
                  end else begin
                     w_bit_cnt = r_bit_cnt + 1'b1;
                     w_tx      = {r_tx[6:0], 1'b0};
                     w_sda_oe  = ~r_tx[6];
                  end
               end
            end
            READ_ACK: begin
               if (w_scl_rise) begin
                  w_ptr = w_ptr_inc;
                  if (w_sda_level) w_state = IDLE;
                  else             w_tx    = w_next_byte;
               end else if (w_scl_fall) begin
                  w_state   = READ;
                  w_bit_cnt = '0;
                  w_sda_oe  = ~r_tx[7];
               end
            end
            default: w_state = IDLE;
         endcase
      end
   end

   assign sda_oe = r_sda_oe;
   assign reg_q  = r_regs;
   assign wr_stb = r_wr_stb;
   assign wr_idx = r_wr_idx;
   assign state  = r_state;
   assign busy   = r_busy;

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

Parametrised I2C slave with a byte-wide register file, successor to the single-byte LED-driving slave. It answers one configurable 7-bit address and supports write (pointer byte, then auto-incrementing data bytes) and read (auto-incrementing from the current pointer). Repeated START is supported. SCL and SDA are sampled against the fabric clock, and SDA is driven open-drain through an output-enable. It sits between the board I2C pads and any logic needing host-writable control registers, such as LED, PWM or mode bits.

## Interface
- I2C_ADDR, 7'h24, 7-bit slave address matched after START
- NUM_REGS, 4, register count, legal range 2..16; pointer width is fixed at 4 bits
- clk  in  1  fabric clock; every flop uses its rising edge
- rst  in  1  asynchronous, active-high reset
- scl  in  1  raw SCL pad input
- sda_in  in  1  raw SDA pad input
- sda_oe  out  1  1 = pull SDA low; the pad is `assign SDA = sda_oe ? 1'b0 : 1'bz`
- reg_q  out  NUM_REGS*8  register file, reg i at bits [8i+7:8i]
- wr_stb  out  1  one-cycle pulse when a register is written
- wr_idx  out  4  index of the register written; valid while wr_stb is high
- state  out  3  current FSM state, for debug
- busy  out  1  high from a detected START until the detected STOP

## Operation
- Input conditioning: scl and sda_in pass through a 2-flop synchronizer. Edge detect compares the previous and current synchronized samples. scl_rise, scl_fall, START (SDA falls while SCL high) and STOP (SDA rises while SCL high) are each single-cycle events.
- FSM states and encodings: IDLE=0, ADDR=1, ADDR_ACK=2, WRITE=3, WRITE_ACK=4, READ=5, READ_ACK=6.
- START from any state: enter ADDR, clear bit_cnt, clear the ptr_loaded flag, set busy. This covers repeated START.
- STOP from any state: enter IDLE, release sda_oe, clear busy. The pointer is retained.
- ADDR: shift SDA in MSB-first on each scl_rise. After the 8th bit:
  - if addr[7:1] == I2C_ADDR, enter ADDR_ACK;
  - otherwise enter IDLE, ignoring the bus until the next START.
- ADDR_ACK: sda_oe goes to 1 on the scl_fall that follows the 8th bit. sda_oe is held until the scl_fall after the 9th clock. At that fall:
  - R/W bit = 0: go to WRITE;
  - R/W bit = 1: go to READ and present the MSB of reg[ptr].
- WRITE: shift 8 bits in. Then:
  - first byte after the address (ptr_loaded = 0): it is the pointer. If value < NUM_REGS, load ptr, set ptr_loaded and ACK. Otherwise NACK and set the drop flag; all following bytes until START/STOP are NACKed and discarded.
  - later bytes: write reg[ptr], pulse wr_stb with wr_idx = ptr, ACK, then advance ptr. ptr wraps from NUM_REGS-1 to 0.
- WRITE_ACK: ACK means sda_oe = 1 during the 9th clock; NACK means sda_oe = 0. Return to WRITE at the 9th scl_fall.
- READ: sda_oe = ~bit. Each bit updates on scl_fall, MSB first, 8 bits.
- READ_ACK: release SDA and sample the master's bit on the 9th scl_rise.
  - 0 (ACK): advance ptr with wrap, load the next byte, present its MSB at scl_fall and continue in READ.
  - 1 (NACK): go to IDLE, waiting for STOP or START. ptr is still advanced.

## Timing
- Reset values: sda_oe=0, reg_q=0, wr_stb=0, wr_idx=0, state=IDLE(0), busy=0, ptr=0. Synchronizer flops reset to 1 (bus idle).
- Event latency: an event is recognised 3 clk after the pad edge without the filter, and 5 clk with I2C_GLITCH_FILTER_EN. SCL high and low phases must each be at least 8 clk.
- Write latency: wr_stb rises 1 clk after the scl_rise event for the 8th data bit, and reg_q updates in that same cycle.
- sda_oe settles within 2 clk of the scl_fall event, which is well before the next SCL rise.
- START and STOP take priority over a bit event detected in the same cycle.
- Reset asserted mid-transfer drops everything at once, including SDA. After release, the bus is ignored until a fresh START.

## Configuration
- I2C_GLITCH_FILTER_EN defined:
  - a 3-sample majority filter follows each synchronizer;
  - a pulse of 1 clk is rejected;
  - event latency becomes 5 clk.
- Not defined: plain 2-flop synchronizer, 3-clk latency, and no spike rejection.

## Structure
- Package i2c_pkg holds:
  - the state encodings as localparams;
  - BITS_PER_BYTE=8;
  - PTR_W=4.
- Sub-module i2c_line_sync contains the synchronizer, the optional filter and the rise/fall detect. It is instantiated once for SCL and once for SDA.

## Test plan
- Write 0x24/W, ptr 0x01, data 0x5A then STOP:
  - ACK on all 3 bytes;
  - reg1 = 0x5A;
  - a single wr_stb with wr_idx = 1;
  - state ends at 0.
- Write 0x24/W, ptr 0x03, data 0x11, 0x22:
  - reg3 = 0x11;
  - ptr wraps, so reg0 = 0x22.
- Write address 0x25:
  - sda_oe stays 0 for the whole transfer;
  - no wr_stb;
  - reg_q unchanged.
- Write 0x24/W, ptr 0x01, then repeated START, 0x24/R, master ACK then NACK:
  - the returned bytes are reg1 and reg2.
- Write ptr 0x07 with NUM_REGS=4:
  - the pointer byte is NACKed;
  - a following data byte 0xAA is NACKed;
  - no register changes.
- Assert rst in the middle of a data byte:
  - all outputs return to their reset values within 1 clk;
  - the next complete transaction succeeds.
